// File: rtl/abs_diff_line_unit_if.sv
// Line-level bus for abs_diff_line_unit: three reference rows and one original row in,
// 25 candidate difference vectors out, each side qualified by a valid strobe.
interface abs_diff_line_unit_if;
   logic        in_valid;
   logic [63:0] cur_upper_pix;
   logic [63:0] cur_middle_pix;
   logic [63:0] cur_lower_pix;
   logic [63:0] org_pix;

   logic        out_valid;
   logic [47:0] diff_UH_h, diff_UH_q, diff_UH_f, diff_UH_r, diff_UH_i;
   logic [47:0] diff_UQ_h, diff_UQ_q, diff_UQ_f, diff_UQ_r, diff_UQ_i;
   logic [47:0] diff_M_h,  diff_M_q,  diff_M_f,  diff_M_r,  diff_M_i;
   logic [47:0] diff_LQ_h, diff_LQ_q, diff_LQ_f, diff_LQ_r, diff_LQ_i;
   logic [47:0] diff_LH_h, diff_LH_q, diff_LH_f, diff_LH_r, diff_LH_i;

   modport master (
      output in_valid, cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix,
      input  out_valid,
      input  diff_UH_h, diff_UH_q, diff_UH_f, diff_UH_r, diff_UH_i,
      input  diff_UQ_h, diff_UQ_q, diff_UQ_f, diff_UQ_r, diff_UQ_i,
      input  diff_M_h,  diff_M_q,  diff_M_f,  diff_M_r,  diff_M_i,
      input  diff_LQ_h, diff_LQ_q, diff_LQ_f, diff_LQ_r, diff_LQ_i,
      input  diff_LH_h, diff_LH_q, diff_LH_f, diff_LH_r, diff_LH_i
   );

   modport slave (
      input  in_valid, cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix,
      output out_valid,
      output diff_UH_h, diff_UH_q, diff_UH_f, diff_UH_r, diff_UH_i,
      output diff_UQ_h, diff_UQ_q, diff_UQ_f, diff_UQ_r, diff_UQ_i,
      output diff_M_h,  diff_M_q,  diff_M_f,  diff_M_r,  diff_M_i,
      output diff_LQ_h, diff_LQ_q, diff_LQ_f, diff_LQ_r, diff_LQ_i,
      output diff_LH_h, diff_LH_q, diff_LH_f, diff_LH_r, diff_LH_i
   );
endinterface

// File: rtl/abs_diff_line_unit.sv
// Quarter-pel bilinear interpolation of one 8-pixel line at 25 candidate offsets, followed by
// per-pixel absolute difference against the original row; single registered output stage.
module abs_diff_line_unit (
   input  logic               clk,
   input  logic               rst,
   abs_diff_line_unit_if.slave bus
);

   // Index order: [v][h], v = dy + 2 (UH..LH), h = dx + 2 (h..i).
   logic [4:0][4:0][47:0] diff_d, diff_q;
   logic                  out_valid_q;

   // Org columns 0 and 7 never take part in a comparison.
   logic unused_org;
   assign unused_org = ^{bus.org_pix[63:56], bus.org_pix[7:0]};

   function automatic logic [7:0] pred_pix(input logic [63:0] mid, input logic [63:0] brw,
                                           input int dx, input int dy, input int j);
      int          cx;
      logic [12:0] wx0, wx1, wy0, wy1, s;
      cx  = j + ((dx > 0) ? 1 : ((dx < 0) ? -1 : 0));
      wx1 = 13'((dx < 0) ? -dx : dx);
      wy1 = 13'((dy < 0) ? -dy : dy);
      wx0 = 13'd4 - wx1;
      wy0 = 13'd4 - wy1;
      // Weights sum to 16, so s <= 16*255 + 8 and the shifted result fits in 8 bits.
      s = wx0 * wy0 * 13'(mid[8*j +: 8]) + wx1 * wy0 * 13'(mid[8*cx +: 8])
        + wx0 * wy1 * 13'(brw[8*j +: 8]) + wx1 * wy1 * 13'(brw[8*cx +: 8]);
      return 8'((s + 13'd8) >> 4);
   endfunction

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   always_comb begin
      logic [63:0] brw;
      diff_d = '0;
      brw    = '0;
      for (int v = 0; v < 5; v++) begin
         if (v < 2)       brw = bus.cur_upper_pix;
         else if (v > 2)  brw = bus.cur_lower_pix;
         else             brw = bus.cur_middle_pix;
         for (int h = 0; h < 5; h++) begin
            for (int m = 0; m < 6; m++) begin
               diff_d[v][h][8*m +: 8] =
                  abs_diff(pred_pix(bus.cur_middle_pix, brw, h - 2, v - 2, m + 1),
                           bus.org_pix[8*(m+1) +: 8]);
            end
         end
      end
   end

   // Outputs refresh every cycle; in_valid only qualifies out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         diff_q      <= diff_d;
         out_valid_q <= bus.in_valid;
      end
   end

   assign bus.out_valid = out_valid_q;

   assign bus.diff_UH_h = diff_q[0][0];
   assign bus.diff_UH_q = diff_q[0][1];
   assign bus.diff_UH_f = diff_q[0][2];
   assign bus.diff_UH_r = diff_q[0][3];
   assign bus.diff_UH_i = diff_q[0][4];
   assign bus.diff_UQ_h = diff_q[1][0];
   assign bus.diff_UQ_q = diff_q[1][1];
   assign bus.diff_UQ_f = diff_q[1][2];
   assign bus.diff_UQ_r = diff_q[1][3];
   assign bus.diff_UQ_i = diff_q[1][4];
   assign bus.diff_M_h  = diff_q[2][0];
   assign bus.diff_M_q  = diff_q[2][1];
   assign bus.diff_M_f  = diff_q[2][2];
   assign bus.diff_M_r  = diff_q[2][3];
   assign bus.diff_M_i  = diff_q[2][4];
   assign bus.diff_LQ_h = diff_q[3][0];
   assign bus.diff_LQ_q = diff_q[3][1];
   assign bus.diff_LQ_f = diff_q[3][2];
   assign bus.diff_LQ_r = diff_q[3][3];
   assign bus.diff_LQ_i = diff_q[3][4];
   assign bus.diff_LH_h = diff_q[4][0];
   assign bus.diff_LH_q = diff_q[4][1];
   assign bus.diff_LH_f = diff_q[4][2];
   assign bus.diff_LH_r = diff_q[4][3];
   assign bus.diff_LH_i = diff_q[4][4];

endmodule

// File: tb/tb_abs_diff_line_unit.sv
// Directed bench for abs_diff_line_unit: expected lines are queued when driven and compared
// one clock later; includes asynchronous reset and in-flight discard checks.
module tb_abs_diff_line_unit;

   typedef struct packed {
      logic              v;
      logic [24:0][47:0] d;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   abs_diff_line_unit_if bus ();

   abs_diff_line_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic exp_t observe();
      exp_t r;
      r.v     = bus.out_valid;
      r.d[0]  = bus.diff_UH_h; r.d[1]  = bus.diff_UH_q; r.d[2]  = bus.diff_UH_f;
      r.d[3]  = bus.diff_UH_r; r.d[4]  = bus.diff_UH_i;
      r.d[5]  = bus.diff_UQ_h; r.d[6]  = bus.diff_UQ_q; r.d[7]  = bus.diff_UQ_f;
      r.d[8]  = bus.diff_UQ_r; r.d[9]  = bus.diff_UQ_i;
      r.d[10] = bus.diff_M_h;  r.d[11] = bus.diff_M_q;  r.d[12] = bus.diff_M_f;
      r.d[13] = bus.diff_M_r;  r.d[14] = bus.diff_M_i;
      r.d[15] = bus.diff_LQ_h; r.d[16] = bus.diff_LQ_q; r.d[17] = bus.diff_LQ_f;
      r.d[18] = bus.diff_LQ_r; r.d[19] = bus.diff_LQ_i;
      r.d[20] = bus.diff_LH_h; r.d[21] = bus.diff_LH_q; r.d[22] = bus.diff_LH_f;
      r.d[23] = bus.diff_LH_r; r.d[24] = bus.diff_LH_i;
      return r;
   endfunction

   // Reference: weighted sum over the 2x2 neighbourhood, rounded, then |pred - org|.
   function automatic exp_t model(logic vld, logic [63:0] u, logic [63:0] m, logic [63:0] l,
                                  logic [63:0] o);
      exp_t r;
      r.v = vld;
      r.d = '0;
      for (int dy = -2; dy <= 2; dy++) begin
         for (int dx = -2; dx <= 2; dx++) begin
            for (int col = 1; col <= 6; col++) begin
               logic [63:0] brow, row;
               int ay, ax, sx, acc, p, ob, dd, w, c;
               brow = (dy < 0) ? u : ((dy > 0) ? l : m);
               ay   = (dy < 0) ? -dy : dy;
               ax   = (dx < 0) ? -dx : dx;
               sx   = (dx > 0) ? 1 : ((dx < 0) ? -1 : 0);
               acc  = 0;
               for (int a = 0; a < 2; a++) begin
                  for (int b = 0; b < 2; b++) begin
                     w   = (a == 1 ? ay : 4 - ay) * (b == 1 ? ax : 4 - ax);
                     c   = (b == 1) ? col + sx : col;
                     row = (a == 1) ? brow : m;
                     acc += w * int'(row[8*c +: 8]);
                  end
               end
               p  = (acc + 8) / 16;
               ob = int'(o[8*col +: 8]);
               dd = (p > ob) ? p - ob : ob - p;
               r.d[(dy + 2) * 5 + dx + 2][8*(col-1) +: 8] = 8'(dd);
            end
         end
      end
      return r;
   endfunction

   function automatic exp_t per_v(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                  logic [7:0] b3, logic [7:0] b4);
      exp_t r;
      logic [7:0] bv [5];
      bv = '{b0, b1, b2, b3, b4};
      r.v = 1'b1;
      for (int i = 0; i < 25; i++) r.d[i] = {6{bv[i / 5]}};
      return r;
   endfunction

   function automatic exp_t per_h(logic [7:0] b0, logic [7:0] b1, logic [7:0] b2,
                                  logic [7:0] b3, logic [7:0] b4);
      exp_t r;
      logic [7:0] bh [5];
      bh = '{b0, b1, b2, b3, b4};
      r.v = 1'b1;
      for (int i = 0; i < 25; i++) r.d[i] = {6{bh[i % 5]}};
      return r;
   endfunction

   task automatic check(string tag, logic [47:0] obs, logic [47:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_line(string tag, exp_t e);
      exp_t o;
      o = observe();
      check($sformatf("%s_valid", tag), 48'(o.v), 48'(e.v));
      for (int i = 0; i < 25; i++)
         check($sformatf("%s_d%0d_%0d", tag, i / 5, i % 5), o.d[i], e.d[i]);
   endtask

   task automatic drive(logic vld, logic [63:0] u, logic [63:0] m, logic [63:0] l,
                        logic [63:0] o, exp_t e);
      bus.in_valid       = vld;
      bus.cur_upper_pix  = u;
      bus.cur_middle_pix = m;
      bus.cur_lower_pix  = l;
      bus.org_pix        = o;
      sb.push_back(e);
   endtask

   task automatic tick(string tag);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s_sb: observed empty queue expected an entry", tag);
      end else begin
         check_line(tag, sb.pop_front());
      end
   endtask

   initial begin
      logic [63:0] ramp, dmid, dlow, ru, rm, rl, ro;
      exp_t        e;
      bus.in_valid       = 1'b0;
      bus.cur_upper_pix  = '0;
      bus.cur_middle_pix = '0;
      bus.cur_lower_pix  = '0;
      bus.org_pix        = '0;
      for (int k = 0; k < 8; k++) begin
         ramp[8*k +: 8] = 8'(16 * k);
         dmid[8*k +: 8] = 8'(4 * k);
         dlow[8*k +: 8] = 8'(4 * k + 4);
      end

      #2;
      check_line("reset_state", exp_t'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      drive(1'b1, {8{8'h10}}, {8{8'h10}}, {8{8'h10}}, {8{8'h10}}, per_v(0, 0, 0, 0, 0));
      tick("flat_equal");
      drive(1'b1, {8{8'h20}}, {8{8'h20}}, {8{8'h20}}, {8{8'h10}},
            per_v(8'h10, 8'h10, 8'h10, 8'h10, 8'h10));
      tick("cur_above_org");
      drive(1'b1, {8{8'h10}}, {8{8'h10}}, {8{8'h10}}, {8{8'h30}},
            per_v(8'h20, 8'h20, 8'h20, 8'h20, 8'h20));
      tick("cur_below_org");
      drive(1'b1, ramp, ramp, ramp, ramp, per_h(8'h08, 8'h04, 8'h00, 8'h04, 8'h08));
      tick("h_ramp");
      drive(1'b1, {8{8'h00}}, {8{8'h40}}, {8{8'h80}}, {8{8'h40}},
            per_v(8'h20, 8'h10, 8'h00, 8'h10, 8'h20));
      tick("v_step");

      e = model(1'b1, 64'h0, dmid, dlow, 64'h0);
      e.d[18] = 48'h1a16120e0a06;
      drive(1'b1, 64'h0, dmid, dlow, 64'h0, e);
      tick("diag_round");

      for (int n = 0; n < 6; n++) begin
         logic vld;
         ru  = {$urandom, $urandom};
         rm  = {$urandom, $urandom};
         rl  = {$urandom, $urandom};
         ro  = {$urandom, $urandom};
         vld = (n != 2);
         drive(vld, ru, rm, rl, ro, model(vld, ru, rm, rl, ro));
         tick($sformatf("rand%0d", n));
      end

      // In-flight line under reset must never surface.
      ru = {8{8'hff}};
      drive(1'b1, ru, 64'h0, ru, 64'h0, model(1'b1, ru, 64'h0, ru, 64'h0));
      tick("pre_reset");
      drive(1'b1, 64'h0, ru, 64'h0, 64'h0, model(1'b1, 64'h0, ru, 64'h0, 64'h0));
      void'(sb.pop_back());
      #2;
      rst = 1'b1;
      #1;
      check_line("async_reset", exp_t'(0));
      @(posedge clk);
      #1;
      check_line("held_reset", exp_t'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_line("post_release", exp_t'(0));

      @(posedge clk);
      #1;
      drive(1'b1, {8{8'h00}}, {8{8'h40}}, {8{8'h80}}, {8{8'h40}},
            per_v(8'h20, 8'h10, 8'h00, 8'h10, 8'h20));
      tick("first_after_reset");

      drive(1'b0, ramp, ramp, ramp, ramp, model(1'b0, ramp, ramp, ramp, ramp));
      tick("idle_line");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
